// File: rtl/function_unit_pkg.sv
// Shared constants and helpers for the FunctionUnit command sequencer.
package function_unit_pkg;

    localparam int DATA_W  = 48;
    localparam int HDR_LEN = 9;

    // Target register codes as presented on reqN_sel.
    typedef enum logic [1:0] {
        SEL_A   = 2'd0,
        SEL_B   = 2'd1,
        SEL_C   = 2'd2,
        SEL_INV = 2'd3
    } sel_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_GAP
    } state_e;

    // "setValue", first character in the most significant byte.
    localparam logic [63:0] HDR_PREFIX = 64'h73657456_616C7565;
    localparam logic [7:0]  LETTER_A   = 8'h41;
    localparam logic [7:0]  LETTER_B   = 8'h42;
    localparam logic [7:0]  LETTER_C   = 8'h43;

    function automatic logic [7:0] sel_letter(input sel_e sel);
        case (sel)
            SEL_A:   return LETTER_A;
            SEL_B:   return LETTER_B;
            SEL_C:   return LETTER_C;
            default: return 8'h00;
        endcase
    endfunction

    // Number of value bytes sent for each target.
    function automatic logic [3:0] payload_len(input sel_e sel);
        case (sel)
            SEL_A:   return 4'd1;
            SEL_B:   return 4'd4;
            SEL_C:   return 4'd6;
            default: return 4'd0;
        endcase
    endfunction

    // Header byte at position idx: eight prefix characters, then the target letter.
    function automatic logic [7:0] hdr_byte(input logic [3:0] idx, input sel_e sel);
        logic [63:0] shifted;
        shifted = HDR_PREFIX << {idx[2:0], 3'b000};
        return (idx < 4'd8) ? shifted[63:56] : sel_letter(sel);
    endfunction

endpackage

// File: rtl/function_unit_rr_arb.sv
// Two-way round-robin arbiter; the pointer favours the requester not granted last.
module function_unit_rr_arb (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant
);

    logic ptr_q;  // 1: favour requester 1 when both are valid
    logic ptr_d;

    // Grant selection and pointer update on an accepted grant.
    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = ptr_q ? 2'b10 : 2'b01;
        end
        ptr_d = ptr_q;
        if (accept && (grant != 2'b00)) begin
            ptr_d = grant[0];
        end
    end

    // Pointer register; reset favours requester 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/function_unit_cmd_sequencer.sv
// Serialises register-write requests from two requesters into FunctionUnit byte frames.
module function_unit_cmd_sequencer
    import function_unit_pkg::*;
#(
    parameter int GAP_CYCLES = 0  // 0..16 extra idle cycles after each frame
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [1:0]        req0_sel,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [1:0]        req1_sel,
    input  logic [DATA_W-1:0] req1_data,
    output logic              io_cmd_valid,
    output logic [7:0]        io_cmd_payload,
    output logic              busy,
    output logic              err_sel
);

    localparam int          GAP_LAST_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [3:0]  GAP_LAST   = GAP_LAST_I[3:0];
    localparam logic [3:0]  HDR_LAST   = 4'(HDR_LEN - 1);
    localparam state_e      POST_FRAME = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    sel_e                sel_q, sel_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   data_shifted;
    logic [1:0]          grant;
    logic                accept_en;
    sel_e                sel_in;

    // Grants are only honoured in IDLE and never while reset is held.
    assign accept_en  = reset && (state_q == ST_IDLE);
    assign req0_ready = accept_en && grant[0];
    assign req1_ready = accept_en && grant[1];
    assign busy       = (state_q != ST_IDLE);

    function_unit_rr_arb u_arb (
        .clk    (clk),
        .reset  (reset),
        .valid  ({req1_valid, req0_valid}),
        .accept (accept_en),
        .grant  (grant)
    );

    // Next-state, counter, shadow capture and byte mux.
    always_comb begin
        // NOTE: every output and next-state variable gets a default here, so no
        // branch of the case below can leave one unassigned and infer a latch.
        state_d        = state_q;
        cnt_d          = cnt_q + 4'd1;
        sel_d          = sel_q;
        data_d         = data_q;
        io_cmd_valid   = 1'b0;
        io_cmd_payload = 8'h00;
        err_sel        = 1'b0;
        sel_in         = grant[1] ? sel_e'(req1_sel) : sel_e'(req0_sel);
        data_shifted   = data_q >> {cnt_q, 3'b000};

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = 4'd0;
                if (accept_en && (grant != 2'b00)) begin
                    sel_d  = sel_in;
                    data_d = grant[1] ? req1_data : req0_data;
                    if (sel_in == SEL_INV) begin
                        err_sel = 1'b1;
                        state_d = POST_FRAME;
                    end else begin
                        state_d = ST_HEADER;
                    end
                end
            end
            ST_HEADER: begin
                io_cmd_valid   = 1'b1;
                io_cmd_payload = hdr_byte(cnt_q, sel_q);
                if (cnt_q == HDR_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                io_cmd_valid   = 1'b1;
                io_cmd_payload = data_shifted[7:0];
                if (cnt_q == payload_len(sel_q) - 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = POST_FRAME;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = 4'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter and shadow registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            sel_q   <= SEL_A;
            data_q  <= '0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the values from
            // before this edge, independent of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_function_unit_cmd_sequencer.sv
// Directed self-checking bench for function_unit_cmd_sequencer.
module tb_function_unit_cmd_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [1:0]  req0_sel, req1_sel;
    logic [47:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        cmd_valid, busy, err_sel;
    logic [7:0]  cmd_payload;

    logic        g_req0_valid, g_req1_valid;
    logic [1:0]  g_req0_sel, g_req1_sel;
    logic [47:0] g_req0_data, g_req1_data;
    logic        g_req0_ready, g_req1_ready;
    logic        g_cmd_valid, g_busy, g_err_sel;
    logic [7:0]  g_cmd_payload;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] fb [0:31];
    int         flen, first_at, bad;

    always #5 clk = ~clk;

    function_unit_cmd_sequencer #(.GAP_CYCLES(0)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel), .req1_data(req1_data),
        .io_cmd_valid(cmd_valid), .io_cmd_payload(cmd_payload), .busy(busy), .err_sel(err_sel)
    );

    function_unit_cmd_sequencer #(.GAP_CYCLES(3)) dut_gap (
        .clk(clk), .reset(reset),
        .req0_valid(g_req0_valid), .req0_ready(g_req0_ready), .req0_sel(g_req0_sel), .req0_data(g_req0_data),
        .req1_valid(g_req1_valid), .req1_ready(g_req1_ready), .req1_sel(g_req1_sel), .req1_data(g_req1_data),
        .io_cmd_valid(g_cmd_valid), .io_cmd_payload(g_cmd_payload), .busy(g_busy), .err_sel(g_err_sel)
    );

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one request at a negedge and check the combinational handshake.
    task automatic issue(input int r, input logic [1:0] sel, input logic [47:0] d, input string tag);
        @(negedge clk);
        if (r == 0) begin
            req0_valid = 1'b1; req0_sel = sel; req0_data = d;
        end else begin
            req1_valid = 1'b1; req1_sel = sel; req1_data = d;
        end
        #1;
        check({tag, "_ready0"}, 72'(req0_ready), 72'(r == 0));
        check({tag, "_ready1"}, 72'(req1_ready), 72'(r == 1));
        check({tag, "_err"},    72'(err_sel),    72'(sel == 2'd3));
    endtask

    // Record the next frame; requests are withdrawn and data scrambled after acceptance.
    task automatic collect();
        flen = 0; first_at = -1; bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            req0_valid = 1'b0; req1_valid = 1'b0;
            req0_data  = 48'hDEAD_BEEF_0000; req1_data = 48'hDEAD_BEEF_0000;
            #1;
            if (cmd_valid) begin
                if (first_at < 0) first_at = c;
                if (flen < 32) fb[flen] = cmd_payload;
                flen++;
                if (!busy) bad++;
            end else begin
                if (cmd_payload !== 8'h00) bad++;
                if (first_at >= 0) break;
            end
        end
    endtask

    // Decode the recorded frame the way FunctionUnit would and compare.
    task automatic check_frame(input string tag, input logic [7:0] letter, input int n, input logic [47:0] value);
        logic [71:0] hdr;
        logic [47:0] val;
        hdr = '0; val = '0;
        for (int k = 0; k < 9; k++) hdr = {hdr[63:0], fb[k]};
        for (int k = 0; k < n && k < 6; k++) val = val | (48'(fb[9 + k]) << (8 * k));
        check({tag, "_len"},    72'(flen),     72'(9 + n));
        check({tag, "_lat"},    72'(first_at), 72'(0));
        check({tag, "_header"}, hdr,           {64'h73657456_616C7565, letter});
        check({tag, "_value"},  72'(val),      72'(value));
        check({tag, "_framing"}, 72'(bad),     72'(0));
    endtask

    initial begin : main
        int quiet, g0, g1, exp_g, both_bad, busy_bad, idle_run, idle_min, idle_max;
        bit seen;
        int phase, f1len, gap_idle, gap_busy;

        reset = 1'b0;
        req0_valid = 1'b1; req0_sel = 2'd0; req0_data = 48'h0;
        req1_valid = 1'b0; req1_sel = 2'd0; req1_data = 48'h0;
        g_req0_valid = 1'b0; g_req0_sel = 2'd0; g_req0_data = 48'h0;
        g_req1_valid = 1'b0; g_req1_sel = 2'd0; g_req1_data = 48'h0;

        // Reset state, with a request held to show ready stays low in reset.
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid",   72'(cmd_valid),   72'(0));
        check("rst_payload", 72'(cmd_payload), 72'(0));
        check("rst_busy",    72'(busy),        72'(0));
        check("rst_err",     72'(err_sel),     72'(0));
        check("rst_ready0",  72'(req0_ready),  72'(0));
        @(negedge clk);
        req0_valid = 1'b0;
        reset = 1'b1;

        // 1: A frame from requester 0.
        issue(0, 2'd0, 48'h0000_0000_005A, "t1");
        collect();
        check_frame("t1", 8'h41, 1, 48'h5A);

        // 2: B frame from requester 1; bits above [31:0] are not sent.
        issue(1, 2'd1, 48'hFFFF_1122_3344, "t2");
        collect();
        check_frame("t2", 8'h42, 4, 48'h1122_3344);

        // 3: C frame from requester 0.
        issue(0, 2'd2, 48'hA1B2_C3D4_E5F6, "t3");
        collect();
        check_frame("t3", 8'h43, 6, 48'hA1B2_C3D4_E5F6);

        // 5: invalid target: handshake + error pulse, no bytes, back to IDLE.
        issue(1, 2'd3, 48'h0, "t5");
        quiet = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            req1_valid = 1'b0;
            #1;
            if (cmd_valid || err_sel || busy || cmd_payload !== 8'h00) quiet++;
        end
        check("t5_quiet", 72'(quiet), 72'(0));

        // 4: both requesters continuously, four requests each; grants alternate from 0.
        g0 = 0; g1 = 0; exp_g = 0; both_bad = 0; busy_bad = 0;
        idle_run = 0; idle_min = 99; idle_max = 0; seen = 1'b0;
        req0_sel = 2'd0; req1_sel = 2'd0;
        for (int c = 0; c < 110; c++) begin
            @(negedge clk);
            req0_valid = (g0 < 4); req1_valid = (g1 < 4);
            req0_data = 48'(8'h10 + g0); req1_data = 48'(8'h20 + g1);
            #1;
            if (req0_ready && req1_ready) both_bad++;
            if ((req0_ready || req1_ready) && busy) busy_bad++;
            if (req0_ready && !req1_ready) begin
                check("t4_grant", 72'(0), 72'(exp_g));
                g0++; exp_g = 1;
            end else if (req1_ready && !req0_ready) begin
                check("t4_grant", 72'(1), 72'(exp_g));
                g1++; exp_g = 0;
            end
            if (cmd_valid) begin
                if (seen && idle_run > 0) begin
                    if (idle_run < idle_min) idle_min = idle_run;
                    if (idle_run > idle_max) idle_max = idle_run;
                end
                seen = 1'b1; idle_run = 0;
            end else if (seen) begin
                idle_run++;
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("t4_g0",       72'(g0),       72'(4));
        check("t4_g1",       72'(g1),       72'(4));
        check("t4_both",     72'(both_bad), 72'(0));
        check("t4_busy_rdy", 72'(busy_bad), 72'(0));
        check("t4_idle_min", 72'(idle_min), 72'(1));
        check("t4_idle_max", 72'(idle_max), 72'(1));

        // 6: reset asserted while header byte 5 of a B frame is on the port.
        issue(0, 2'd1, 48'h0000_CAFE_F00D, "t6a");
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            req0_valid = 1'b0;
        end
        #1;
        check("t6_byte5", 72'({cmd_valid, cmd_payload}), 72'({1'b1, 8'h6C}));
        #2 reset = 1'b0;
        #1;
        check("t6_abort_valid",   72'(cmd_valid),   72'(0));
        check("t6_abort_payload", 72'(cmd_payload), 72'(0));
        check("t6_abort_busy",    72'(busy),        72'(0));
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("t6_rst_ready", 72'({req1_ready, req0_ready}), 72'(0));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        req0_sel = 2'd0; req0_data = 48'h3C;
        req1_sel = 2'd1; req1_data = 48'h1234;
        #1;
        check("t6_ptr_ready", 72'({req1_ready, req0_ready}), 72'(2'b01));
        collect();
        check_frame("t6", 8'h41, 1, 48'h3C);

        // GAP_CYCLES=3 build: back-to-back A frames are separated by 4 idle cycles.
        phase = 0; f1len = 0; gap_idle = 0; gap_busy = 0;
        @(negedge clk);
        g_req0_valid = 1'b1; g_req0_sel = 2'd0; g_req0_data = 48'h77;
        for (int c = 0; c < 40 && phase != 3; c++) begin
            @(negedge clk);
            #1;
            case (phase)
                0: if (g_cmd_valid) begin phase = 1; f1len = 1; end
                1: if (g_cmd_valid) f1len++;
                   else begin phase = 2; gap_idle = 1; gap_busy = int'(g_busy); end
                2: if (g_cmd_valid) phase = 3;
                   else begin gap_idle++; gap_busy += int'(g_busy); end
                default: ;
            endcase
        end
        g_req0_valid = 1'b0;
        check("gap_phase", 72'(phase),    72'(3));
        check("gap_f1len", 72'(f1len),    72'(10));
        check("gap_idle",  72'(gap_idle), 72'(4));
        check("gap_busy",  72'(gap_busy), 72'(3));

        repeat (20) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
